// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator front end: the four user phases
// (whose encoding is also the IDLE value seen by the display selector and
// the RGB LED driver) and the ALU opcode constants.
// No ports; imported with "import calc_pkg::*".
// -----------------------------------------------------------------------------
package calc_pkg;

    // Phase encoding doubles as the IDLE output, so the values are fixed.
    typedef enum logic [1:0] {
        S_OP1    = 2'b00,
        S_OP2    = 2'b01,
        S_OPSEL  = 2'b10,
        S_RESULT = 2'b11
    } calc_state_t;

    // Opcodes carried on ALU_CTRL.
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // True while the result is on display.
    function automatic logic is_result(input calc_state_t s);
        return (s == S_RESULT);
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Turns one raw, bouncing, asynchronous push-button into a single-cycle
// pulse per press.
//   CLK      in   system clock
//   RESET    in   asynchronous, active-high reset
//   BTN_RAW  in   raw button level (asynchronous)
//   PULSE    out  one-cycle pulse on each accepted press (registered)
// Press latency from the first edge sampling the button high is
// 2 + DEBOUNCE_CYCLES cycles; releases and short glitches give no pulse.
// -----------------------------------------------------------------------------
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic BTN_RAW,
    output logic PULSE
);

    localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             stable;
    logic             last_stable;
    logic [CNT_W-1:0] count;

    // The counter only runs while the synchronised level disagrees with the
    // accepted level; any sample that agrees restarts it, so a change is
    // accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    // The pulse is taken from the stable/last_stable pair one cycle after
    // the stable level rises, which keeps it fully registered.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_a      <= 1'b0;
            sync_b      <= 1'b0;
            stable      <= 1'b0;
            last_stable <= 1'b0;
            count       <= '0;
            PULSE       <= 1'b0;
        end else begin
            sync_a      <= BTN_RAW;
            sync_b      <= sync_a;
            last_stable <= stable;
            PULSE       <= stable & ~last_stable;
            if (sync_b == stable) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                stable <= sync_b;
                count  <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// -----------------------------------------------------------------------------
// calc_sequencer
// Front-end controller for the calculator datapath. Walks the user through
// operand 1, operand 2, operation select and result, with undo and result
// chaining.
//   CLK        in   system clock
//   RESET      in   asynchronous, active-high reset
//   SW         in   WIDTH raw value switches (asynchronous, quasi-static)
//   BTN_ENTER  in   raw button: accept the phase and advance
//   BTN_UNDO   in   raw button: step back one phase
//   BTN_CHAIN  in   raw button: reuse the result as operand 1
//   RESULTADO  in   WIDTH ALU result
//   OVERFLOW   in   ALU error flag
//   OP_1       out  WIDTH registered operand 1
//   OP_2       out  WIDTH registered operand 2
//   ALU_CTRL   out  2 registered opcode
//   IDLE       out  2 current phase (display select / LED)
//   DONE       out  high while in the result phase
// -----------------------------------------------------------------------------
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] SW,
    input  logic             BTN_ENTER,
    input  logic             BTN_UNDO,
    input  logic             BTN_CHAIN,
    input  logic [WIDTH-1:0] RESULTADO,
    input  logic             OVERFLOW,
    output logic [WIDTH-1:0] OP_1,
    output logic [WIDTH-1:0] OP_2,
    output logic [1:0]       ALU_CTRL,
    output logic [1:0]       IDLE,
    output logic             DONE
);

    calc_state_t      state;
    calc_state_t      state_next;
    logic [WIDTH-1:0] op1_next;
    logic [WIDTH-1:0] op2_next;
    logic [1:0]       ctrl_next;
    logic [WIDTH-1:0] sw_sync_a;
    logic [WIDTH-1:0] sw_sync_b;
    logic             enter_pulse;
    logic             undo_pulse;
    logic             chain_pulse;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .CLK     (CLK),
        .RESET   (RESET),
        .BTN_RAW (BTN_ENTER),
        .PULSE   (enter_pulse)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_undo (
        .CLK     (CLK),
        .RESET   (RESET),
        .BTN_RAW (BTN_UNDO),
        .PULSE   (undo_pulse)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chain (
        .CLK     (CLK),
        .RESET   (RESET),
        .BTN_RAW (BTN_CHAIN),
        .PULSE   (chain_pulse)
    );

    // Switch bus synchroniser; the switches are quasi-static so a plain
    // two-flop bus is adequate.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sw_sync_a <= '0;
            sw_sync_b <= '0;
        end else begin
            sw_sync_a <= SW;
            sw_sync_b <= sw_sync_a;
        end
    end

    // Phase, operand and opcode registers. DONE is registered from the next
    // phase so it always agrees with IDLE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= S_OP1;
            OP_1     <= '0;
            OP_2     <= '0;
            ALU_CTRL <= 2'b00;
            DONE     <= 1'b0;
        end else begin
            state    <= state_next;
            OP_1     <= op1_next;
            OP_2     <= op2_next;
            ALU_CTRL <= ctrl_next;
            DONE     <= is_result(state_next);
        end
    end

    // The current phase's register tracks the switches every cycle; button
    // pulses then override it. UNDO beats ENTER beats CHAIN, and losing
    // pulses are simply dropped. UNDO in the first phase has nowhere to go
    // back to, so it clears operand 1 for a cycle instead.
    always_comb begin
        state_next = state;
        op1_next   = OP_1;
        op2_next   = OP_2;
        ctrl_next  = ALU_CTRL;
        case (state)
            S_OP1: begin
                op1_next = sw_sync_b;
                if (undo_pulse) begin
                    op1_next = '0;
                end else if (enter_pulse) begin
                    state_next = S_OP2;
                end
            end
            S_OP2: begin
                op2_next = sw_sync_b;
                if (undo_pulse) begin
                    state_next = S_OP1;
                end else if (enter_pulse) begin
                    state_next = S_OPSEL;
                end
            end
            S_OPSEL: begin
                ctrl_next = sw_sync_b[1:0];
                if (undo_pulse) begin
                    state_next = S_OP2;
                end else if (enter_pulse) begin
                    state_next = S_RESULT;
                end
            end
            S_RESULT: begin
                if (undo_pulse) begin
                    state_next = S_OPSEL;
                end else if (enter_pulse) begin
                    state_next = S_OP1;
                end else if (chain_pulse && !OVERFLOW) begin
                    op1_next   = RESULTADO;
                    state_next = S_OP2;
                end
            end
            default: begin
                state_next = S_OP1;
            end
        endcase
    end

    assign IDLE = state;

endmodule

// File: tb/tb_calc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_sequencer
// Self-checking bench for calc_sequencer with DEBOUNCE_CYCLES = 4.
// A behavioural model (phase number, switch delay line, window-of-samples
// debouncer) is stepped on every rising edge and compared every falling edge;
// a vector table and hand-written sequences add fixed expectations.
// -----------------------------------------------------------------------------
module tb_calc_sequencer;

    localparam int WIDTH = 16;
    localparam int DEB   = 4;

    localparam int B_ENTER = 0;
    localparam int B_UNDO  = 1;
    localparam int B_CHAIN = 2;

    localparam logic [2:0] BM_NONE  = 3'b000;
    localparam logic [2:0] BM_ENTER = 3'b001;
    localparam logic [2:0] BM_UNDO  = 3'b010;
    localparam logic [2:0] BM_CHAIN = 3'b100;

    typedef struct packed {
        logic [15:0] sw;
        logic [2:0]  btn;
        logic [15:0] res;
        logic        ovf;
        logic [1:0]  exp_idle;
        logic        exp_done;
        logic [15:0] exp_op1;
        logic [15:0] exp_op2;
        logic [1:0]  exp_ctrl;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] sw = '0;
    logic [2:0]       btn_drv = '0;
    logic [WIDTH-1:0] resultado = '0;
    logic             overflow = 1'b0;
    logic [WIDTH-1:0] op_1;
    logic [WIDTH-1:0] op_2;
    logic [1:0]       alu_ctrl;
    logic [1:0]       idle;
    logic             done;

    int num_checks = 0;
    int num_fails  = 0;

    // Reference model state
    int          m_phase = 0;
    logic [15:0] m_op1 = '0;
    logic [15:0] m_op2 = '0;
    logic [1:0]  m_ctrl = '0;
    logic [2:0]  m_stable = '0;
    logic [2:0]  m_stage1 = '0;
    logic [2:0]  m_stage2 = '0;
    logic [15:0] sw_q[$];
    logic [2:0]  btn_q[$];

    calc_sequencer #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .SW        (sw),
        .BTN_ENTER (btn_drv[B_ENTER]),
        .BTN_UNDO  (btn_drv[B_UNDO]),
        .BTN_CHAIN (btn_drv[B_CHAIN]),
        .RESULTADO (resultado),
        .OVERFLOW  (overflow),
        .OP_1      (op_1),
        .OP_2      (op_2),
        .ALU_CTRL  (alu_ctrl),
        .IDLE      (idle),
        .DONE      (done)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Hard stop in case something stalls the stimulus.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic modelReset();
        m_phase  = 0;
        m_op1    = '0;
        m_op2    = '0;
        m_ctrl   = '0;
        m_stable = '0;
        m_stage1 = '0;
        m_stage2 = '0;
        sw_q.delete();
        sw_q.push_back('0);
        sw_q.push_back('0);
        btn_q.delete();
        for (int i = 0; i <= DEB; i++) btn_q.push_back('0);
    endtask

    // One rising edge of the model. A press is accepted once the last DEB
    // synchronised samples all disagree with the accepted level; the pulse
    // acts on the phase two edges later.
    task automatic modelStep();
        logic [2:0]  fire;
        logic [2:0]  all_diff;
        logic [15:0] sw_d;
        if (rst) begin
            modelReset();
            return;
        end
        fire = m_stage2;
        sw_d = sw_q[0];
        case (m_phase)
            0: m_op1 = sw_d;
            1: m_op2 = sw_d;
            2: m_ctrl = sw_d[1:0];
            default: ;
        endcase
        if (fire[B_UNDO]) begin
            if (m_phase == 0) m_op1 = '0;
            else m_phase = m_phase - 1;
        end else if (fire[B_ENTER]) begin
            m_phase = (m_phase + 1) % 4;
        end else if (fire[B_CHAIN] && m_phase == 3 && !overflow) begin
            m_op1   = resultado;
            m_phase = 1;
        end
        all_diff = 3'b111;
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < DEB; i++)
                if (btn_q[i][b] == m_stable[b]) all_diff[b] = 1'b0;
        m_stage2 = m_stage1;
        m_stage1 = all_diff & ~m_stable;
        m_stable = m_stable ^ all_diff;
        void'(sw_q.pop_front());
        sw_q.push_back(sw);
        void'(btn_q.pop_front());
        btn_q.push_back(btn_drv);
    endtask

    task automatic checkModel();
        logic [1:0] e_idle;
        e_idle = 2'(m_phase);
        num_checks++;
        if ({idle, done, op_1, op_2, alu_ctrl} !==
            {e_idle, (m_phase == 3), m_op1, m_op2, m_ctrl}) begin
            num_fails++;
            $display("[TB] FAIL model_track @%0t: got idle=%0d done=%0d op1=%h op2=%h ctrl=%0d, expected idle=%0d done=%0d op1=%h op2=%h ctrl=%0d",
                     $time, idle, done, op_1, op_2, alu_ctrl,
                     e_idle, (m_phase == 3), m_op1, m_op2, m_ctrl);
        end
    endtask

    task automatic checkOutput(input string name, input logic [15:0] got,
                               input logic [15:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock: model sees the rising edge, outputs checked on the falling.
    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkModel();
    endtask

    task automatic pressButton(input logic [2:0] mask, input int hold,
                               input int rest);
        btn_drv = mask;
        repeat (hold) tick();
        btn_drv = BM_NONE;
        repeat (rest) tick();
    endtask

    task automatic applyStimulus(input vec_t v);
        sw        = v.sw;
        resultado = v.res;
        overflow  = v.ovf;
        repeat (4) tick();
        pressButton(v.btn, 10, 10);
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        checkOutput({tag, "_idle"}, 16'(idle), 16'(v.exp_idle));
        checkOutput({tag, "_done"}, 16'(done), 16'(v.exp_done));
        checkOutput({tag, "_op1"},  op_1, v.exp_op1);
        checkOutput({tag, "_op2"},  op_2, v.exp_op2);
        checkOutput({tag, "_ctrl"}, 16'(alu_ctrl), 16'(v.exp_ctrl));
    endtask

    initial begin
        vec_t vecs[9];
        int   remain[3];

        //            sw        btn       res       ovf  idle  done op1       op2       ctrl
        vecs[0] = '{16'h0012, BM_ENTER, 16'h0000, 1'b0, 2'b01, 1'b0, 16'h0012, 16'h0012, 2'b00};
        vecs[1] = '{16'h0034, BM_ENTER, 16'h0000, 1'b0, 2'b10, 1'b0, 16'h0012, 16'h0034, 2'b00};
        vecs[2] = '{16'h0002, BM_ENTER, 16'h0000, 1'b0, 2'b11, 1'b1, 16'h0012, 16'h0034, 2'b10};
        vecs[3] = '{16'h0002, BM_CHAIN, 16'h0046, 1'b1, 2'b11, 1'b1, 16'h0012, 16'h0034, 2'b10};
        vecs[4] = '{16'h0099, BM_CHAIN, 16'h0046, 1'b0, 2'b01, 1'b0, 16'h0046, 16'h0099, 2'b10};
        vecs[5] = '{16'h0003, BM_ENTER, 16'h0046, 1'b0, 2'b10, 1'b0, 16'h0046, 16'h0003, 2'b11};
        vecs[6] = '{16'h0055, BM_UNDO,  16'h0046, 1'b0, 2'b01, 1'b0, 16'h0046, 16'h0055, 2'b01};
        vecs[7] = '{16'h00FF, BM_UNDO,  16'h0046, 1'b0, 2'b00, 1'b0, 16'h00FF, 16'h00FF, 2'b01};
        vecs[8] = '{16'h0021, BM_CHAIN, 16'h0046, 1'b0, 2'b00, 1'b0, 16'h0021, 16'h00FF, 2'b01};

        modelReset();
        #1 rst = 1'b1;
        repeat (3) tick();
        checkOutput("reset_idle", 16'(idle), 16'h0000);
        checkOutput("reset_done", 16'(done), 16'h0000);
        checkOutput("reset_op1", op_1, 16'h0000);
        checkOutput("reset_op2", op_2, 16'h0000);
        checkOutput("reset_ctrl", 16'(alu_ctrl), 16'h0000);
        rst = 1'b0;
        repeat (2) tick();

        $display("[TB] vector table");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            checkVector(i, vecs[i]);
        end

        $display("[TB] glitch shorter than debounce window");
        pressButton(BM_ENTER, 3, 20);
        checkOutput("glitch_idle", 16'(idle), 16'h0000);

        $display("[TB] undo in operand 1 phase");
        sw = 16'h00FF;
        repeat (4) tick();
        checkOutput("undo1_before", op_1, 16'h00FF);
        btn_drv = BM_UNDO;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 8) checkOutput("undo1_cleared", op_1, 16'h0000);
            if (i == 9) checkOutput("undo1_resumed", op_1, 16'h00FF);
        end
        btn_drv = BM_NONE;
        repeat (10) tick();

        $display("[TB] long hold gives one transition after 7 cycles");
        btn_drv = BM_ENTER;
        for (int i = 1; i <= 50; i++) begin
            tick();
            checkOutput($sformatf("hold_idle_c%0d", i), 16'(idle),
                        (i >= 8) ? 16'h0001 : 16'h0000);
        end
        btn_drv = BM_NONE;
        repeat (10) tick();
        checkOutput("hold_release_idle", 16'(idle), 16'h0001);

        $display("[TB] simultaneous enter and undo");
        pressButton(BM_ENTER | BM_UNDO, 10, 10);
        checkOutput("simul_idle", 16'(idle), 16'h0000);
        pressButton(BM_CHAIN, 10, 10);
        checkOutput("chain_op1_idle", 16'(idle), 16'h0000);

        $display("[TB] reset in result phase");
        for (int i = 0; i < 3; i++) pressButton(BM_ENTER, 10, 10);
        checkOutput("pre_reset_done", 16'(done), 16'h0001);
        #2 rst = 1'b1;
        modelReset();
        #1;
        checkOutput("async_rst_idle", 16'(idle), 16'h0000);
        checkOutput("async_rst_done", 16'(done), 16'h0000);
        checkOutput("async_rst_op1", op_1, 16'h0000);
        checkOutput("async_rst_op2", op_2, 16'h0000);
        checkOutput("async_rst_ctrl", 16'(alu_ctrl), 16'h0000);
        btn_drv = BM_ENTER;
        repeat (3) tick();
        rst = 1'b0;
        repeat (30) tick();
        checkOutput("held_through_reset_idle", 16'(idle), 16'h0001);
        btn_drv = BM_NONE;
        repeat (10) tick();
        checkOutput("held_release_idle", 16'(idle), 16'h0001);

        $display("[TB] randomized run against model");
        remain = '{0, 0, 0};
        for (int c = 0; c < 2500; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (remain[b] == 0) begin
                    btn_drv[b] = ($urandom_range(0, 2) == 0);
                    remain[b]  = btn_drv[b] ? int'($urandom_range(1, 12))
                                            : int'($urandom_range(4, 30));
                end else begin
                    remain[b]--;
                end
            end
            if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
            resultado = 16'($urandom);
            overflow  = ($urandom_range(0, 2) == 0);
            tick();
        end
        btn_drv = BM_NONE;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 num_checks, num_fails);
        $finish;
    end

endmodule
